// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle MIPS control unit.
//
// Walks each instruction through fetch, decode, execute, memory and write-back
// states. Drives ALUOp and every datapath strobe from the current state.
// Waits on a memory-ready handshake and counts retired instructions.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Op, Funct       opcode and function fields of the instruction register
//   Zero            ALU equality flag, used by beq only
//   mem_ready       memory finishes the current access this cycle
//   PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, MemtoReg,
//   ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp
//                   datapath controls, decoded from the current state
//   illegal         one-cycle pulse in DECODE for an unsupported instruction
//   state           current state, for debug
//   instr_cnt       retired-instruction counter, wraps at 2^32
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        EXTOp,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALUOp,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXE    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ORI    = 4'd9,
        S_ADDI   = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_OR   = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b110;

    state_t cur;
    state_t nxt;
    state_t dstate;
    logic   retire;

    assign state = cur;

    // While reset is held the outputs must look like an idle FETCH, whatever
    // state the register still holds, so decode from FETCH in that case.
    assign dstate = rst ? S_FETCH : cur;

    // An instruction retires on its last cycle; a store only once memory has
    // accepted it.
    assign retire = (cur == S_MEMWB) || (cur == S_ALUWB) || (cur == S_BEQ) ||
                    (cur == S_IMMWB) || (cur == S_JUMP) ||
                    ((cur == S_MEMWR) && mem_ready);

    // Output decode and next-state logic. Only mem_ready and Zero reach the
    // strobes directly; everything else is a pure function of the state.
    always_comb begin
        nxt      = cur;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        EXTOp    = 1'b0;
        PCSource = 2'b00;
        ALUOp    = ALU_ADD;
        illegal  = 1'b0;
        case (dstate)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                EXTOp   = 1'b1;
                case (Op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE: begin
                        if (Funct == FN_ADDU || Funct == FN_SUBU ||
                            Funct == FN_OR   || Funct == FN_SLT) begin
                            nxt = S_EXE;
                        end else begin
                            nxt     = S_FETCH;
                            illegal = 1'b1;
                        end
                    end
                    OP_BEQ:   nxt = S_BEQ;
                    OP_ORI:   nxt = S_ORI;
                    OP_ADDIU: nxt = S_ADDI;
                    OP_J:     nxt = S_JUMP;
                    default: begin
                        nxt     = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                nxt     = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                nxt  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                nxt      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FN_SUBU: ALUOp = ALU_SUB;
                    FN_OR:   ALUOp = ALU_OR;
                    FN_SLT:  ALUOp = ALU_SLT;
                    default: ALUOp = ALU_ADD;
                endcase
                nxt = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                PCWrite  = Zero;
                nxt      = S_FETCH;
            end
            S_ORI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_OR;
                nxt     = S_IMMWB;
            end
            S_ADDI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                nxt     = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                nxt      = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    // State register and retired-instruction counter. Reset abandons any
    // instruction in flight and clears the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= S_FETCH;
            instr_cnt <= 32'd0;
        end else begin
            cur <= nxt;
            if (retire) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// Each vector holds one cycle of inputs plus the state, control word and
// instruction count expected during that cycle. Vectors are pushed onto a
// scoreboard when driven and popped when the outputs have settled.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  Op = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, MemtoReg;
    logic        ALUSrcA, EXTOp, illegal;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic [31:0] instr_cnt;
    logic [16:0] ctrlOut;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .IorD(IorD), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .PCSource(PCSource),
        .ALUOp(ALUOp), .illegal(illegal), .state(state),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Control word layout:
    // PCWrite IRWrite IorD MemWrite RegWrite RegDst MemtoReg ALUSrcA
    // ALUSrcB[1:0] EXTOp PCSource[1:0] ALUOp[2:0] illegal
    assign ctrlOut = {PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst,
                      MemtoReg, ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp,
                      illegal};

    localparam logic [16:0] C_FR   = 17'b1_1_0_0_0_0_0_0_01_0_00_010_0;
    localparam logic [16:0] C_FW   = 17'b0_0_0_0_0_0_0_0_01_0_00_010_0;
    localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_11_1_00_010_0;
    localparam logic [16:0] C_DECI = 17'b0_0_0_0_0_0_0_0_11_1_00_010_1;
    localparam logic [16:0] C_MADR = 17'b0_0_0_0_0_0_0_1_10_1_00_010_0;
    localparam logic [16:0] C_MRD  = 17'b0_0_1_0_0_0_0_0_00_0_00_010_0;
    localparam logic [16:0] C_MWB  = 17'b0_0_0_0_1_0_1_0_00_0_00_010_0;
    localparam logic [16:0] C_MWR  = 17'b0_0_1_1_0_0_0_0_00_0_00_010_0;
    localparam logic [16:0] C_EADD = 17'b0_0_0_0_0_0_0_1_00_0_00_010_0;
    localparam logic [16:0] C_ESUB = 17'b0_0_0_0_0_0_0_1_00_0_00_011_0;
    localparam logic [16:0] C_EOR  = 17'b0_0_0_0_0_0_0_1_00_0_00_000_0;
    localparam logic [16:0] C_ESLT = 17'b0_0_0_0_0_0_0_1_00_0_00_110_0;
    localparam logic [16:0] C_AWB  = 17'b0_0_0_0_1_1_0_0_00_0_00_010_0;
    localparam logic [16:0] C_BEQT = 17'b1_0_0_0_0_0_0_1_00_0_01_011_0;
    localparam logic [16:0] C_BEQN = 17'b0_0_0_0_0_0_0_1_00_0_01_011_0;
    localparam logic [16:0] C_ORI  = 17'b0_0_0_0_0_0_0_1_10_0_00_000_0;
    localparam logic [16:0] C_ADDI = 17'b0_0_0_0_0_0_0_1_10_1_00_010_0;
    localparam logic [16:0] C_IWB  = 17'b0_0_0_0_1_0_0_0_00_0_00_010_0;
    localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_0_00_0_10_010_0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_ADI = 6'b001001;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] cnt;
        logic        chk;
    } vec_t;

    vec_t tbl[$];
    vec_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   vecNum = 0;

    function automatic vec_t mk(input logic r, input logic [5:0] o,
                                input logic [5:0] f, input logic z,
                                input logic m, input logic [3:0] s,
                                input logic [16:0] c, input logic [31:0] n,
                                input logic k);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = m;
        v.st = s; v.ctrl = c; v.cnt = n; v.chk = k;
        return v;
    endfunction

    // Drive one cycle of inputs after the falling edge and record what the
    // design should show during that cycle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        Op        = v.op;
        Funct     = v.funct;
        Zero      = v.zero;
        mem_ready = v.rdy;
        expQ.push_back(v);
    endtask

    // Let the decode settle, then compare against the oldest expectation.
    task automatic checkOutput();
        vec_t e;
        #2;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard vec %0d: got empty queue, required an entry", vecNum);
        end else begin
            e = expQ.pop_front();
            if (ctrlOut !== e.ctrl) begin
                errors++;
                $display("[TB] FAIL ctrl vec %0d: got %b required %b", vecNum, ctrlOut, e.ctrl);
            end
            if (e.chk) begin
                checks += 2;
                if (state !== e.st) begin
                    errors++;
                    $display("[TB] FAIL state vec %0d: got %0d required %0d", vecNum, state, e.st);
                end
                if (instr_cnt !== e.cnt) begin
                    errors++;
                    $display("[TB] FAIL instr_cnt vec %0d: got %0d required %0d", vecNum, instr_cnt, e.cnt);
                end
            end
        end
        vecNum++;
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: fill the vector table, replay it, then run the
    // hand-written stall and reset-in-store sequences.
    initial begin
        logic [5:0]  rFn[4];
        logic [16:0] rExe[4];
        int          stallF;
        int          stallM;
        logic [31:0] cnt;

        rFn  = '{6'b100011, 6'b100101, 6'b101010, 6'b100001};
        rExe = '{C_ESUB, C_EOR, C_ESLT, C_EADD};

        // Reset held two cycles; state/count are only known after the first edge
        tbl.push_back(mk(1, OP_R, 6'd0, 0, 0, 4'd0, C_FW, 32'd0, 0));
        tbl.push_back(mk(1, OP_R, 6'd0, 0, 1, 4'd0, C_FW, 32'd0, 1));
        // lw, memory always ready
        tbl.push_back(mk(0, OP_LW, 6'd0, 0, 1, 4'd0, C_FR,   32'd0, 1));
        tbl.push_back(mk(0, OP_LW, 6'd0, 0, 1, 4'd1, C_DEC,  32'd0, 1));
        tbl.push_back(mk(0, OP_LW, 6'd0, 0, 1, 4'd2, C_MADR, 32'd0, 1));
        tbl.push_back(mk(0, OP_LW, 6'd0, 0, 1, 4'd3, C_MRD,  32'd0, 1));
        tbl.push_back(mk(0, OP_LW, 6'd0, 0, 1, 4'd4, C_MWB,  32'd0, 1));
        // sw with three wait cycles in MEMWR
        tbl.push_back(mk(0, OP_SW, 6'd0, 0, 1, 4'd0, C_FR,   32'd1, 1));
        tbl.push_back(mk(0, OP_SW, 6'd0, 0, 1, 4'd1, C_DEC,  32'd1, 1));
        tbl.push_back(mk(0, OP_SW, 6'd0, 0, 1, 4'd2, C_MADR, 32'd1, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, OP_SW, 6'd0, 0, 0, 4'd5, C_MWR, 32'd1, 1));
        tbl.push_back(mk(0, OP_SW, 6'd0, 0, 1, 4'd5, C_MWR,  32'd1, 1));
        // one fetch wait cycle
        tbl.push_back(mk(0, OP_R, 6'b100001, 0, 0, 4'd0, C_FW, 32'd2, 1));
        // R-type: subu, or, slt, addu
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, OP_R, rFn[i], 0, 1, 4'd0, C_FR,    32'(2 + i), 1));
            tbl.push_back(mk(0, OP_R, rFn[i], 0, 1, 4'd1, C_DEC,   32'(2 + i), 1));
            tbl.push_back(mk(0, OP_R, rFn[i], 0, 1, 4'd6, rExe[i], 32'(2 + i), 1));
            tbl.push_back(mk(0, OP_R, rFn[i], 0, 1, 4'd7, C_AWB,   32'(2 + i), 1));
        end
        // beq taken, then not taken (Zero high outside BEQ must not matter)
        tbl.push_back(mk(0, OP_BEQ, 6'd0, 1, 1, 4'd0, C_FR,   32'd6, 1));
        tbl.push_back(mk(0, OP_BEQ, 6'd0, 1, 1, 4'd1, C_DEC,  32'd6, 1));
        tbl.push_back(mk(0, OP_BEQ, 6'd0, 1, 1, 4'd8, C_BEQT, 32'd6, 1));
        tbl.push_back(mk(0, OP_BEQ, 6'd0, 1, 1, 4'd0, C_FR,   32'd7, 1));
        tbl.push_back(mk(0, OP_BEQ, 6'd0, 1, 1, 4'd1, C_DEC,  32'd7, 1));
        tbl.push_back(mk(0, OP_BEQ, 6'd0, 0, 1, 4'd8, C_BEQN, 32'd7, 1));
        // j
        tbl.push_back(mk(0, OP_J, 6'd0, 0, 1, 4'd0,  C_FR,  32'd8, 1));
        tbl.push_back(mk(0, OP_J, 6'd0, 0, 1, 4'd1,  C_DEC, 32'd8, 1));
        tbl.push_back(mk(0, OP_J, 6'd0, 0, 1, 4'd12, C_JMP, 32'd8, 1));
        // ori, addiu
        tbl.push_back(mk(0, OP_ORI, 6'd0, 0, 1, 4'd0,  C_FR,   32'd9,  1));
        tbl.push_back(mk(0, OP_ORI, 6'd0, 0, 1, 4'd1,  C_DEC,  32'd9,  1));
        tbl.push_back(mk(0, OP_ORI, 6'd0, 0, 1, 4'd9,  C_ORI,  32'd9,  1));
        tbl.push_back(mk(0, OP_ORI, 6'd0, 0, 1, 4'd11, C_IWB,  32'd9,  1));
        tbl.push_back(mk(0, OP_ADI, 6'd0, 0, 1, 4'd0,  C_FR,   32'd10, 1));
        tbl.push_back(mk(0, OP_ADI, 6'd0, 0, 1, 4'd1,  C_DEC,  32'd10, 1));
        tbl.push_back(mk(0, OP_ADI, 6'd0, 0, 1, 4'd10, C_ADDI, 32'd10, 1));
        tbl.push_back(mk(0, OP_ADI, 6'd0, 0, 1, 4'd11, C_IWB,  32'd10, 1));
        // illegal opcode, then illegal R-type funct; neither retires
        tbl.push_back(mk(0, OP_BAD, 6'd0, 0, 1, 4'd0, C_FR,   32'd11, 1));
        tbl.push_back(mk(0, OP_BAD, 6'd0, 0, 1, 4'd1, C_DECI, 32'd11, 1));
        tbl.push_back(mk(0, OP_R, 6'b001000, 0, 1, 4'd0, C_FR,   32'd11, 1));
        tbl.push_back(mk(0, OP_R, 6'b001000, 0, 1, 4'd1, C_DECI, 32'd11, 1));

        $display("[TB] replaying %0d table vectors", tbl.size());
        foreach (tbl[i]) runVec(tbl[i]);

        // lw with random stalls in FETCH and MEMRD
        cnt    = 32'd11;
        stallF = $urandom_range(1, 4);
        stallM = $urandom_range(1, 5);
        for (int i = 0; i < stallF; i++)
            runVec(mk(0, OP_LW, 6'd0, 0, 0, 4'd0, C_FW, cnt, 1));
        runVec(mk(0, OP_LW, 6'd0, 0, 1, 4'd0, C_FR,   cnt, 1));
        runVec(mk(0, OP_LW, 6'd0, 0, 1, 4'd1, C_DEC,  cnt, 1));
        runVec(mk(0, OP_LW, 6'd0, 0, 0, 4'd2, C_MADR, cnt, 1));
        for (int i = 0; i < stallM; i++)
            runVec(mk(0, OP_LW, 6'd0, 0, 0, 4'd3, C_MRD, cnt, 1));
        runVec(mk(0, OP_LW, 6'd0, 0, 1, 4'd3, C_MRD, cnt, 1));
        runVec(mk(0, OP_LW, 6'd0, 0, 1, 4'd4, C_MWB, cnt, 1));
        cnt = cnt + 32'd1;

        // sw interrupted by reset while waiting in MEMWR
        runVec(mk(0, OP_SW, 6'd0, 0, 1, 4'd0, C_FR,   cnt, 1));
        runVec(mk(0, OP_SW, 6'd0, 0, 1, 4'd1, C_DEC,  cnt, 1));
        runVec(mk(0, OP_SW, 6'd0, 0, 1, 4'd2, C_MADR, cnt, 1));
        runVec(mk(0, OP_SW, 6'd0, 0, 0, 4'd5, C_MWR,  cnt, 1));
        runVec(mk(1, OP_SW, 6'd0, 0, 0, 4'd5, C_FW,   cnt, 0));
        runVec(mk(0, OP_SW, 6'd0, 0, 0, 4'd0, C_FW,   32'd0, 1));
        runVec(mk(0, OP_SW, 6'd0, 0, 1, 4'd0, C_FR,   32'd0, 1));
        runVec(mk(0, OP_SW, 6'd0, 0, 1, 4'd1, C_DEC,  32'd0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle MIPS control unit: the sequential producer of `ALUOp` and every datapath control strobe for the multicycle CPU. It sits between the instruction register (`Op`/`Funct`) and the datapath. The datapath ALU consumes its `ALUOp` and returns `Zero` (A == B). It adds a memory wait handshake and a retired-instruction counter.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `Op` in 6: `IR[31:26]`. Stable from the cycle after the fetch `IRWrite`.
- `Funct` in 6: `IR[5:0]`.
- `Zero` in 1: ALU equality flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC load.
- `IRWrite` out 1: IR load.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register file write.
- `RegDst` out 1: write register select. 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-back data select. 0 = ALUOut, 1 = MDR.
- `ALUSrcA` out 1: ALU A select. 0 = PC, 1 = regA.
- `ALUSrcB` out 2: ALU B select.
  - 00 = regB
  - 01 = constant 4
  - 10 = extended immediate
  - 11 = extended immediate << 2
- `EXTOp` out 1: immediate extension. 1 = sign-extend, 0 = zero-extend.
- `PCSource` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp` out 3: ALU operation.
  - 000 = OR
  - 010 = ADD
  - 011 = SUB
  - 110 = signed SLT
- `illegal` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state, for debug.
- `instr_cnt` out 32: count of retired instructions.

## Operation
- Outputs are decoded from `state`. `mem_ready` and `Zero` gate only the strobes noted below.
- Any output not listed for a state is 0, except `ALUOp`, which defaults to 010.
- State encodings and behaviour:
  - FETCH(0): `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=010, `PCSource`=00.
    - `IRWrite` = `PCWrite` = `mem_ready`.
    - Go to DECODE when `mem_ready`=1, otherwise stay.
  - DECODE(1): `ALUSrcA`=0, `ALUSrcB`=11, `EXTOp`=1, `ALUOp`=010. This precomputes the branch target into ALUOut. Next state by `Op`:
    - 100011 lw or 101011 sw → MEMADR
    - 000000 → EXE if `Funct` ∈ {100001 addu, 100011 subu, 100101 or, 101010 slt}
    - 000100 beq → BEQ
    - 001101 ori → ORI
    - 001001 addiu → ADDI
    - 000010 j → JUMP
    - any other `Op`/`Funct` → FETCH with `illegal`=1 this cycle
  - MEMADR(2): `ALUSrcA`=1, `ALUSrcB`=10, `EXTOp`=1, `ALUOp`=010. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD(3): `IorD`=1. Go to MEMWB on `mem_ready`, otherwise stay.
  - MEMWB(4): `RegWrite`=1, `RegDst`=0, `MemtoReg`=1 → FETCH.
  - MEMWR(5): `IorD`=1, `MemWrite`=1, held for the whole state. Go to FETCH on `mem_ready`, otherwise stay.
  - EXE(6): `ALUSrcA`=1, `ALUSrcB`=00. `ALUOp` by funct: addu→010, subu→011, or→000, slt→110. → ALUWB.
  - ALUWB(7): `RegWrite`=1, `RegDst`=1, `MemtoReg`=0 → FETCH.
  - BEQ(8): `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=011, `PCSource`=01, `PCWrite`=`Zero` → FETCH.
  - ORI(9): `ALUSrcA`=1, `ALUSrcB`=10, `EXTOp`=0, `ALUOp`=000 → IMMWB.
  - ADDI(10): `ALUSrcA`=1, `ALUSrcB`=10, `EXTOp`=1, `ALUOp`=010 → IMMWB.
  - IMMWB(11): `RegWrite`=1, `RegDst`=0, `MemtoReg`=0 → FETCH.
  - JUMP(12): `PCSource`=10, `PCWrite`=1 → FETCH.
  - Encodings 13–15 are unreachable. If entered, go to FETCH with all strobes 0.
- `instr_cnt` increments by 1 on the final cycle of every legal instruction: MEMWB, MEMWR with `mem_ready`, ALUWB, BEQ, IMMWB, JUMP.
  - It wraps from 0xFFFFFFFF to 0.
  - Illegal instructions are not counted.

## Timing
- Reset: on an `rst`=1 clock edge, `state` ← FETCH and `instr_cnt` ← 0.
- While `rst`=1:
  - `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `illegal` are forced to 0.
  - All other outputs are the FETCH values.
- Reset mid-instruction abandons the instruction; no further write strobe is issued.
- Cycles per instruction with `mem_ready` tied high:
  - lw 5
  - sw 4
  - R-type 4
  - ori/addiu 4
  - beq 3
  - j 3
  - illegal 2
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle.
- `Zero` is sampled combinationally in BEQ only.
- Write strobes never assert in DECODE, MEMADR, EXE, ORI or ADDI.

## Test plan
- Reset: `rst`=1 for 2 cycles then release → `state`=0, `instr_cnt`=0, and the first `IRWrite`=1/`PCWrite`=1 pulse one cycle later with `mem_ready`=1.
- lw (`Op`=100011), `mem_ready`=1 → states 0,1,2,3,4,0; `RegWrite`=1 with `MemtoReg`=1 only in state 4; `instr_cnt` 0→1.
- sw with `mem_ready` low for 3 cycles in MEMWR → `MemWrite` held 4 cycles; exit on the cycle `mem_ready`=1; `RegWrite` never asserts.
- R-type (`Funct` = 100011, 100101, 101010, 100001) → `ALUOp` in EXE = 011, 000, 110, 010; ALUWB has `RegDst`=1.
- beq with `Zero`=1 then `Zero`=0 → `PCWrite`=1 with `PCSource`=01 on the first, `PCWrite`=0 on the second; `instr_cnt` +2. j → `PCSource`=10, `PCWrite`=1.
- `Op`=111111 → `illegal` pulses for 1 cycle in DECODE, return to FETCH, `instr_cnt` unchanged. `rst` asserted in MEMWR → no `MemWrite` on the next cycle, `state`=0.
